imem_resp_model: RTL and testbench
==================================

// Module: imem_resp_model
// PURPOSE
// - Parametrised instruction-memory responder driving the Sodor core imem port in simulation harnesses.
// - Replaces a hardwired instruction constant with a loadable program store.
// - Adds configurable response latency, periodic stall injection and an out-of-range fill instruction.
// - Sits between the testbench and Core (io_imem_req_* / io_imem_resp_*). Synthesizable; no sim-only constructs.
// PARAMETERS
// - XLEN         32            data/address width
// - DEPTH        64            program words; power of 2, >= 2
// - BASE_ADDR    32'h0         byte address of word 0
// - LATENCY      1             cycles from req to resp; 0..7, 0 = combinational
// - STALL_EVERY  0             after N serviced slots, force one invalid slot; 0 = never
// - FILL_INSN    32'h00000013  data returned for out-of-range/misaligned addresses (NOP)
// PORTS
// - clock                   in   1           core clock
// - reset                   in   1           synchronous, active-high
// - load_en                 in   1           program-store write strobe
// - load_addr               in   log2(DEPTH) word index to write
// - load_data               in   XLEN        word to write
// - io_imem_req_valid       in   1           core fetch request
// - io_imem_req_bits_addr   in   XLEN        fetch byte address
// - io_imem_resp_valid      out  1           response valid
// - io_imem_resp_bits_data  out  XLEN        fetched instruction
// - resp_count              out  32          number of valid responses, saturating
// - oob_seen                out  1           sticky: some accepted request was out of range or misaligned
// BEHAVIOUR
// - Reset values: resp_valid=0, resp_bits_data=0, resp_count=0, oob_seen=0; stall counter=0; delay line cleared.
// - Reset does NOT clear the program store. Loads are accepted during reset, so the bench preloads before release.
// - Load: on the clock edge with load_en=1, mem[load_addr] <= load_data.
// - Read-during-write to the same word returns the old value; the new value is visible from the next cycle.
// - Address decode: idx = (addr - BASE_ADDR) >> 2.
//   - In range iff addr >= BASE_ADDR, idx < DEPTH and addr[1:0] == 0.
//   - Otherwise data = FILL_INSN and oob_seen <= 1, held until reset.
// - Slot/stall scheme: stall counter cnt counts 0..STALL_EVERY and advances every cycle outside reset.
//   - If STALL_EVERY != 0 and cnt == STALL_EVERY, the cycle is a stall slot: request ignored (no oob update), cnt <= 0.
//   - Otherwise, if req_valid=1, the request is accepted and cnt <= cnt + 1.
//   - Otherwise, with no request, cnt holds.
// - LATENCY=0: resp_valid = accepted && !reset, combinationally in the same cycle; data read asynchronously.
// - LATENCY=L>0: an accepted request at cycle t yields resp_valid=1 and its data at cycle t+L.
//   - Non-accepted cycles yield resp_valid=0, data=0 at t+L.
//   - Fully pipelined: one request per cycle, responses in order, no back-pressure.
// - Data is captured at acceptance; loads after acceptance do not alter in-flight responses.
// - resp_count increments each cycle resp_valid=1 and saturates at 32'hFFFF_FFFF.
// - Reset mid-flight: all in-flight responses are discarded; resp_valid=0 from the cycle after the reset edge (LATENCY>0).
// - Address arithmetic: modulo 2^XLEN; addr < BASE_ADDR is detected by compare before the subtraction.
// STRUCTURE
// - Shared package sodor_tb_pkg holds:
//   - RV_NOP constant (32'h00000013)
//   - XLEN default
//   - imem response struct {valid, data}
//   - function in_range(addr, base, depth)
// - One sub-module, imem_resp_pipe: LATENCY-deep {valid,data} delay line with synchronous clear; pass-through when LATENCY=0.
// - Top holds the program store, decode, stall counter, resp_count and oob_seen.
// TESTING
// - LATENCY=0: preload mem[0]=32'h00200313, release reset, req addr 0 -> same cycle resp_valid=1, data=32'h00200313.
// - LATENCY=2: back-to-back reqs to addrs 0,4,8 from cycle t -> valid data mem[0],mem[1],mem[2] at t+2,t+3,t+4.
// - DEPTH=64: req addr 32'h400 -> data 32'h00000013, oob_seen=1 and held. Req addr 2 (misaligned) -> fill data.
// - STALL_EVERY=3, LATENCY=1, continuous reqs for 8 cycles -> resp_valid 1,1,1,0,1,1,1,0 and resp_count=6.
// - LATENCY=2 with 2 requests in flight: assert reset 1 cycle -> no valid response emerges, resp_count=0.
//   Re-read addr 0 afterwards -> preloaded value returned (store retained).
// - LATENCY=0: load mem[1]=X while reading addr 4 -> old word this cycle, X on the next cycle.

Source files
------------

// File: rtl/sodor_tb_pkg.sv
// Shared types and helpers for the Sodor simulation-harness memory models.
// Holds the NOP encoding, the imem response record and the address range check.
package sodor_tb_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } imem_resp_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_ACCEPT,
    SLOT_STALL
  } slot_e;

  // The base compare happens before the subtraction so addresses below base never wrap into range.
  function automatic logic in_range(input logic [XLEN-1:0] addr,
                                    input logic [XLEN-1:0] base,
                                    input int unsigned     depth);
    logic [XLEN-1:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> 2) < XLEN'(depth)) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// LATENCY-deep {valid,data} delay line with synchronous clear.
// With LATENCY=0 the response passes straight through, forced to zero during reset.
module imem_resp_pipe
  import sodor_tb_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  imem_resp_t in_i,
  output imem_resp_t out_o
);

  if (LATENCY == 0) begin : g_comb
    logic unused_clk;
    assign unused_clk = clk_i;

    always_comb begin
      out_o = in_i;
      if (rst_i) out_o = '0;
    end
  end else begin : g_pipe
    imem_resp_t stage_q [LATENCY];
    imem_resp_t stage_d [LATENCY];

    always_comb begin
      stage_d[0] = in_i;
      for (int unsigned i = 1; i < LATENCY; i++) stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < LATENCY; i++) stage_q[i] <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign out_o = stage_q[LATENCY-1];
  end

endmodule

// File: rtl/imem_resp_model.sv
// Instruction-memory responder for the Sodor core imem port: loadable store,
// configurable latency, periodic stall slots and fill data for bad addresses.
module imem_resp_model #(
  parameter int unsigned     XLEN        = sodor_tb_pkg::XLEN,
  parameter int unsigned     DEPTH       = 64,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int unsigned     LATENCY     = 1,
  parameter int unsigned     STALL_EVERY = 0,
  parameter logic [XLEN-1:0] FILL_INSN   = sodor_tb_pkg::RV_NOP
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  input  logic                     io_imem_req_valid,
  input  logic [XLEN-1:0]          io_imem_req_bits_addr,
  output logic                     io_imem_resp_valid,
  output logic [XLEN-1:0]          io_imem_resp_bits_data,
  output logic [31:0]              resp_count,
  output logic                     oob_seen
);

  import sodor_tb_pkg::*;

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned CW   = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     resp_count_q;
  logic            oob_q;

  slot_e           slot;
  logic            req_ok;
  logic [IDXW-1:0] idx;
  logic [XLEN-1:0] rdata;
  imem_resp_t      pipe_in, pipe_out;

  // Program store is never reset so it can be preloaded while reset is held.
  always_ff @(posedge clock) begin
    if (load_en) mem_q[load_addr] <= load_data;
  end

  always_comb begin
    req_ok = in_range(io_imem_req_bits_addr, BASE_ADDR, DEPTH);
    idx    = IDXW'((io_imem_req_bits_addr - BASE_ADDR) >> 2);
    rdata  = req_ok ? mem_q[idx] : FILL_INSN;

    if ((STALL_EVERY != 0) && (cnt_q == CW'(STALL_EVERY))) begin
      slot = SLOT_STALL;
    end else if (io_imem_req_valid) begin
      slot = SLOT_ACCEPT;
    end else begin
      slot = SLOT_IDLE;
    end

    cnt_d = cnt_q;
    unique case (slot)
      SLOT_STALL:  cnt_d = '0;
      SLOT_ACCEPT: if (STALL_EVERY != 0) cnt_d = cnt_q + CW'(1);
      default:     cnt_d = cnt_q;
    endcase

    pipe_in = '0;
    if (slot == SLOT_ACCEPT) begin
      pipe_in.valid = 1'b1;
      pipe_in.data  = rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      resp_count_q <= '0;
      oob_q        <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (io_imem_resp_valid && (resp_count_q != '1)) resp_count_q <= resp_count_q + 32'd1;
      if ((slot == SLOT_ACCEPT) && !req_ok) oob_q <= 1'b1;
    end
  end

  imem_resp_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk_i(clock),
    .rst_i(reset),
    .in_i (pipe_in),
    .out_o(pipe_out)
  );

  assign io_imem_resp_valid     = pipe_out.valid;
  assign io_imem_resp_bits_data = pipe_out.data;
  assign resp_count             = resp_count_q;
  assign oob_seen               = oob_q;

endmodule

// File: tb/tb_imem_resp_model.sv
// Bench for imem_resp_model: three instances (latency 0, latency 2, latency 1 with stalls)
// share one stimulus stream and are compared every cycle against a cycle-indexed model.
module tb_imem_resp_model;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        req_valid;
  logic [31:0] req_addr;

  logic [2:0]       rv, oo;
  logic [2:0][31:0] rd, rc;

  always #5 clock = ~clock;

  imem_resp_model #(.LATENCY(0)) u_l0 (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .io_imem_req_valid(req_valid), .io_imem_req_bits_addr(req_addr),
    .io_imem_resp_valid(rv[0]), .io_imem_resp_bits_data(rd[0]), .resp_count(rc[0]), .oob_seen(oo[0])
  );

  imem_resp_model #(.LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .io_imem_req_valid(req_valid), .io_imem_req_bits_addr(req_addr),
    .io_imem_resp_valid(rv[1]), .io_imem_resp_bits_data(rd[1]), .resp_count(rc[1]), .oob_seen(oo[1])
  );

  imem_resp_model #(.LATENCY(1), .STALL_EVERY(3)) u_st (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .io_imem_req_valid(req_valid), .io_imem_req_bits_addr(req_addr),
    .io_imem_resp_valid(rv[2]), .io_imem_resp_bits_data(rd[2]), .resp_count(rc[2]), .oob_seen(oo[2])
  );

  int unsigned lat [3] = '{0, 2, 1};
  int unsigned stl [3] = '{0, 0, 3};

  // Expected output of cycle c for a pipelined instance lives at slot c % 16.
  logic [31:0] mem_m [64];
  int unsigned svc   [3];
  logic        oob_m [3];
  logic [31:0] cnt_m [3];
  logic        ev    [3][16];
  logic [31:0] ed    [3][16];

  int unsigned cyc;
  int          errors;
  int          checks;

  function automatic logic model_in_range(input logic [31:0] a);
    logic [63:0] lo, hi;
    lo = 64'd0;
    hi = lo + 64'd256;
    return (a % 4 == 0) && ({32'd0, a} >= lo) && ({32'd0, a} < hi);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic le, input logic [5:0] la, input logic [31:0] ldat,
                      input logic qv, input logic [31:0] qa);
    logic        acc [3];
    logic [31:0] fd  [3];
    logic        evv [3];
    logic [31:0] edd [3];
    logic        inr;
    logic        stall;
    int unsigned s;

    reset     = r;
    load_en   = le;
    load_addr = la;
    load_data = ldat;
    req_valid = qv;
    req_addr  = qa;

    inr = model_in_range(qa);
    s   = cyc % 16;
    for (int k = 0; k < 3; k++) begin
      stall  = (stl[k] != 0) && (svc[k] == stl[k]);
      acc[k] = qv && !stall && !r;
      fd[k]  = acc[k] ? (inr ? mem_m[qa[7:2]] : 32'h0000_0013) : 32'd0;
      if (lat[k] == 0) begin
        evv[k] = acc[k];
        edd[k] = fd[k];
      end else begin
        evv[k] = ev[k][s];
        edd[k] = ed[k][s];
      end
    end

    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_valid", k), {31'd0, rv[k]}, {31'd0, evv[k]});
      chk($sformatf("u%0d_data", k),  rd[k], edd[k]);
      chk($sformatf("u%0d_count", k), rc[k], cnt_m[k]);
      chk($sformatf("u%0d_oob", k),   {31'd0, oo[k]}, {31'd0, oob_m[k]});
    end

    for (int k = 0; k < 3; k++) begin
      if (r) begin
        cnt_m[k] = 0;
        oob_m[k] = 1'b0;
        svc[k]   = 0;
        for (int j = 0; j < 16; j++) begin
          ev[k][j] = 1'b0;
          ed[k][j] = 32'd0;
        end
      end else begin
        if (evv[k]) cnt_m[k] = cnt_m[k] + 1;
        if (acc[k] && !inr) oob_m[k] = 1'b1;
        if ((stl[k] != 0) && (svc[k] == stl[k])) svc[k] = 0;
        else if (acc[k]) svc[k] = svc[k] + 1;
        if (lat[k] > 0) begin
          ev[k][(cyc + lat[k]) % 16] = acc[k];
          ed[k][(cyc + lat[k]) % 16] = fd[k];
        end
      end
    end
    if (le) mem_m[la] = ldat;

    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel;

    errors = 0;
    checks = 0;
    cyc    = 0;
    for (int k = 0; k < 3; k++) begin
      svc[k]   = 0;
      oob_m[k] = 1'b0;
      cnt_m[k] = 0;
      for (int j = 0; j < 16; j++) begin
        ev[k][j] = 1'b0;
        ed[k][j] = 32'd0;
      end
    end
    for (int j = 0; j < 64; j++) mem_m[j] = 32'd0;

    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    @(posedge clock);
    #1;

    // Preload the whole store while reset is held.
    for (int i = 0; i < 64; i++)
      step(1'b1, 1'b1, 6'(i), (i == 0) ? 32'h0020_0313 : $urandom, 1'b0, 32'd0);

    idle(1);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd0);
    idle(2);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'(4 * i));
    idle(3);

    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'h0000_0400);
    idle(2);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'h0000_0002);
    idle(3);
    chk("oob_sticky_l0", {31'd0, oo[0]}, 32'd1);

    // Stall pattern from a freshly reset counter.
    step(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'(4 * i));
    idle(2);
    chk("stall_resp_count", rc[2], 32'd6);

    // Reset with responses in flight, then re-read the retained store.
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd4);
    step(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0);
    idle(3);
    chk("flush_count_l2", rc[1], 32'd0);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd0);
    idle(3);
    chk("reread_count_l2", rc[1], 32'd1);

    // Read-during-write on word 1.
    step(1'b0, 1'b1, 6'd1, 32'hCAFE_0001, 1'b1, 32'd4);
    step(1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 32'd4);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (sel == 6) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 7) a = 32'h0000_0100;
      else if (sel == 8) a = 32'h0000_00FC;
      else               a = $urandom;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, 6'($urandom_range(0, 63)),
           $urandom, $urandom_range(0, 3) != 0, a);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
